// File: rtl/register_file_if.sv
// register_file_if -- bundle of the register file's read and write ports.
//
// Signals:
//   read_reg1, read_reg2 : read indices (Rn, Rm/Rt)
//   write_reg            : write index (Rd)
//   write_data           : value to store
//   reg_write            : write enable
//   read_data1/2         : combinational read results
//
// Handshake: there is no valid/ready pair. Reads are always valid,
// combinationally, for whatever indices are presented. A write is requested
// by reg_write=1 and is taken, without back-pressure, at the next rising clk
// edge.
//
// Modports: master drives indices and write data; slave is the register file.
interface register_file_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2
  );
endinterface

// File: rtl/register_file.sv
// register_file -- two-read, one-write architectural register file.
//
// The highest index (X31 when ADDR_WIDTH=5) is the zero register (XZR). It
// has no storage, always reads as 0, and writes to it are dropped.
//
// Ports:
//   clk   : clock; all state changes on its rising edge
//   rst_n : synchronous active-low reset; clears every register
//   rf    : register_file_if.slave (read/write index and data bundle)
//
// Parameters:
//   DATA_WIDTH : register width (default 64)
//   ADDR_WIDTH : index width (default 5, giving X0..X31)
//
// Build option:
//   REGFILE_BYPASS_EN : when defined, a read of the register being written in
//   the same cycle returns write_data, combinationally. When not defined, that
//   read returns the old stored value. Stored contents are the same either
//   way.
module register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input logic            clk,
  input logic            rst_n,
  register_file_if.slave rf
);
  localparam int                    NUM_REGS = (2 ** ADDR_WIDTH) - 1;
  localparam logic [ADDR_WIDTH-1:0] XZR      = '1;

  logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  // Reset is part of the enable so that the bypass path is off while reset
  // is asserted.
  assign wr_en = rst_n && rf.reg_write && (rf.write_reg != XZR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rf.write_reg] <= rf.write_data;
    end
  end

  always_comb begin
    rd1 = (rf.read_reg1 == XZR) ? '0 : regs[rf.read_reg1];
    rd2 = (rf.read_reg2 == XZR) ? '0 : regs[rf.read_reg2];
`ifdef REGFILE_BYPASS_EN
    // Write-through: forward the incoming value ahead of the write edge.
    if (wr_en && (rf.read_reg1 == rf.write_reg)) rd1 = rf.write_data;
    if (wr_en && (rf.read_reg2 == rf.write_reg)) rd2 = rf.write_data;
`else
    // Reads of the register being written return the old value; the new
    // value appears only after the write edge.
`endif
  end

  assign rf.read_data1 = rd1;
  assign rf.read_data2 = rd2;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file -- testbench for register_file.
// The reference model is a 32-entry array in which entry 31 always reads 0.
// Expected read pairs go into a queue when stimulus is applied. A monitor
// compares them at the falling edge.
module tb_register_file;
  localparam int W  = 64;
  localparam int AW = 5;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  register_file_if #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) rf_bus ();

  register_file #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] model [0:31];
  bit           chk_en = 1'b0;

  function automatic logic [W-1:0] model_read(input logic [AW-1:0] idx, input bit rst,
                                              input bit we, input logic [AW-1:0] widx,
                                              input logic [W-1:0] wdata);
    logic [W-1:0] v;
    v = (idx == 5'd31) ? '0 : model[idx];
`ifdef REGFILE_BYPASS_EN
    if (rst && we && widx != 5'd31 && idx == widx) v = wdata;
`endif
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  string          name_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: got d1=%h d2=%h required a queued expectation",
                 rf_bus.read_data1, rf_bus.read_data2);
      end else begin
        logic [2*W-1:0] e;
        string          n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if ({rf_bus.read_data1, rf_bus.read_data2} !== e) begin
          bad++;
          $display("FAIL %s: got d1=%h d2=%h required d1=%h d2=%h", n,
                   rf_bus.read_data1, rf_bus.read_data2, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Applies one cycle of stimulus (#1 after posedge), queues the expected
  // pre-edge reads, then consumes one rising edge and updates the model.
  task automatic drive_cycle(input bit rst, input bit we, input logic [AW-1:0] widx,
                             input logic [W-1:0] wdata, input logic [AW-1:0] r1,
                             input logic [AW-1:0] r2, input bit check, input string name);
    rst_n             = rst;
    rf_bus.reg_write  = we;
    rf_bus.write_reg  = widx;
    rf_bus.write_data = wdata;
    rf_bus.read_reg1  = r1;
    rf_bus.read_reg2  = r2;
    chk_en            = check;
    if (check) begin
      exp_q.push_back({model_read(r1, rst, we, widx, wdata), model_read(r2, rst, we, widx, wdata)});
      name_q.push_back(name);
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we && widx != 5'd31) begin
      model[widx] = wdata;
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ones;
    ones = '1;
    rst_n = 1'b0;
    rf_bus.reg_write = 1'b0;
    rf_bus.write_reg = '0;
    rf_bus.write_data = '0;
    rf_bus.read_reg1 = '0;
    rf_bus.read_reg2 = '0;
    @(posedge clk);
    #1;

    // Two reset edges; contents are undefined before the first one.
    drive_cycle(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, "reset_a");
    drive_cycle(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, "reset_b");

    // All indices read zero on both ports.
    for (int i = 0; i < 32; i++) begin
      drive_cycle(1'b1, 1'b0, 5'd0, '0, 5'(i), 5'(31 - i), 1'b1, "reset_read_all");
    end

    // Write X5 and X6, then read both.
    drive_cycle(1'b1, 1'b1, 5'd5, 64'd5, 5'd0, 5'd1, 1'b1, "write_x5");
    drive_cycle(1'b1, 1'b1, 5'd6, 64'd6, 5'd5, 5'd2, 1'b1, "write_x6");
    drive_cycle(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd6, 1'b1, "read_x5_x6");

    // A write to XZR is dropped.
    drive_cycle(1'b1, 1'b1, 5'd31, ones, 5'd31, 5'd31, 1'b1, "xzr_write_cycle");
    drive_cycle(1'b1, 1'b0, 5'd0, '0, 5'd31, 5'd31, 1'b1, "xzr_read");

    // With the enable low, nothing is stored.
    drive_cycle(1'b1, 1'b0, 5'd8, 64'd56, 5'd8, 5'd8, 1'b1, "enable_low_cycle");
    drive_cycle(1'b1, 1'b0, 5'd0, '0, 5'd8, 5'd8, 1'b1, "enable_low_read");

    // Reset wins over a simultaneous write; the bypass is off while in reset.
    drive_cycle(1'b1, 1'b1, 5'd7, 64'h77, 5'd5, 5'd6, 1'b1, "prefill_x7");
    drive_cycle(1'b0, 1'b1, 5'd7, 64'd7, 5'd7, 5'd5, 1'b1, "reset_priority_cycle");
    drive_cycle(1'b1, 1'b0, 5'd0, '0, 5'd7, 5'd5, 1'b1, "reset_priority_read");

    // Read of the register being written in the same cycle.
    drive_cycle(1'b1, 1'b1, 5'd9, 64'd1, 5'd0, 5'd0, 1'b1, "x9_set_1");
    drive_cycle(1'b1, 1'b1, 5'd9, 64'd42, 5'd9, 5'd9, 1'b1, "hazard_pre_edge");
    drive_cycle(1'b1, 1'b0, 5'd0, '0, 5'd9, 5'd10, 1'b1, "hazard_post_edge");

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      bit           r;
      bit           we;
      logic [AW-1:0] wi;
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      logic [W-1:0]  d;
      r  = ($urandom_range(0, 49) != 0);
      we = ($urandom_range(0, 3) != 0);
      wi = 5'($urandom_range(0, 31));
      d  = {$urandom(), $urandom()};
      a  = ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 31));
      b  = ($urandom_range(0, 4) == 0) ? a  : 5'($urandom_range(0, 31));
      drive_cycle(r, we, wi, d, a, b, 1'b1, "random");
    end

    chk_en = 1'b0;
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL declare parameter DATA_WIDTH, default 64, meaning register and data-port width.
REQ-002 The block SHALL declare parameter ADDR_WIDTH, default 5, meaning register-index width (32 architectural registers X0..X31).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 The block SHALL have port read_reg1, input, ADDR_WIDTH, the read port 1 index (source Rn).
REQ-006 The block SHALL have port read_reg2, input, ADDR_WIDTH, the read port 2 index (source Rm/Rt).
REQ-007 The block SHALL have port write_reg, input, ADDR_WIDTH, the write index (destination Rd).
REQ-008 The block SHALL have port write_data, input, DATA_WIDTH, the value to write.
REQ-009 The block SHALL have port reg_write, input, 1, the write enable.
REQ-010 The block SHALL have port read_data1, output, DATA_WIDTH, the port 1 value; it drives the ALU a_in operand.
REQ-011 The block SHALL have port read_data2, output, DATA_WIDTH, the port 2 value; it drives the ALU b_in operand or the store data.

Function
REQ-012 Storage SHALL be 31 registers of DATA_WIDTH bits (X0..X30); X31 is XZR and SHALL have no storage.
REQ-013 Reads SHALL be combinational, with zero-cycle latency from read_regN to read_dataN.
REQ-014 Any read of index 31 SHALL return 0 on both ports.
REQ-015 A write SHALL occur at the rising clk edge when rst_n=1, reg_write=1 and write_reg!=31.
REQ-016 After such a write, the new value SHALL be visible on reads from that edge onward.
REQ-017 A write to index 31 SHALL be discarded, with no state change.
REQ-018 reg_write=0 SHALL leave all registers unchanged regardless of write_reg and write_data.
REQ-019 Both read ports SHALL operate independently.
REQ-020 read_reg1 == read_reg2 SHALL return identical values on both ports.
REQ-021 A same-cycle read of the register being written SHALL follow REQ-033/REQ-034.
REQ-022 write_data SHALL be stored unmodified at full DATA_WIDTH, with no truncation or sign handling.
REQ-023 X/Z on read_reg indices SHALL affect only the corresponding read_data, never the stored state.

Reset
REQ-024 At a rising clk edge with rst_n=0, all 31 registers SHALL clear to 0.
REQ-025 Reset SHALL take priority over any simultaneous write; that write is lost.
REQ-026 While rst_n=0 and before the first reset edge, read ports SHALL reflect the current (possibly uninitialised) contents.
REQ-027 After the first reset edge, read_data1 and read_data2 SHALL be 0 for every index.
REQ-028 If reset is asserted mid-sequence (between writes), all prior writes SHALL be lost.
REQ-029 The first write after reset SHALL be accepted at the first rising edge with rst_n=1.
REQ-030 While rst_n=0, the write-bypass path (REQ-033) SHALL be disabled.

Configuration
REQ-031 The macro REGFILE_BYPASS_EN SHALL select write-through bypass.
REQ-032 Without REGFILE_BYPASS_EN, a same-cycle read of write_reg SHALL return the old stored value.
REQ-033 With REGFILE_BYPASS_EN defined, when rst_n=1, reg_write=1, write_reg!=31 and read_regN==write_reg, read_dataN SHALL equal write_data combinationally in that cycle.
REQ-034 Without REGFILE_BYPASS_EN, the new value SHALL appear only after the write edge.
REQ-035 Storage contents after every edge SHALL be identical in both configurations.

Verification
REQ-036 Reset: rst_n=0 for 2 edges, then read every index 0..31 on both ports -> all read 0.
REQ-037 Write/read: write X5=5 and X6=6 on consecutive edges; read_reg1=5, read_reg2=6 -> read_data1=5, read_data2=6 (ALU add result 11).
REQ-038 XZR: write 64'hFFFF_FFFF_FFFF_FFFF to index 31; read index 31 -> 0 on both ports.
REQ-039 Enable: reg_write=0, write_reg=8, write_data=56 -> X8 unchanged (0).
REQ-040 Reset priority: rst_n=0 with reg_write=1, write_reg=7, write_data=7 at the same edge -> X7=0.
REQ-041 Same-cycle hazard: X9 holds 1; reg_write=1, write_reg=9, write_data=42, read_reg1=9 -> read_data1=42 pre-edge if REGFILE_BYPASS_EN is defined, else 1; 42 post-edge in both configurations.
